// File: rtl/frame_rr_arbiter_if.sv
// Frame-stream bundle between PORT_COUNT ingress queues, the round-robin arbiter
// and the shared egress register stage.
interface frame_rr_arbiter_if #(
  parameter int PORT_COUNT = 4,
  parameter int WORD_WIDTH = 64
);
  logic [PORT_COUNT-1:0]            in_valid;
  logic [PORT_COUNT-1:0]            in_ready;
  logic [PORT_COUNT*WORD_WIDTH-1:0] in_data;
  logic [PORT_COUNT-1:0]            in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [WORD_WIDTH-1:0]            out_data;
  logic                             out_last;
  logic [PORT_COUNT-1:0]            grant;
  logic                             busy;

  // Source/sink side: drives requests and downstream ready.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, grant, busy
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, grant, busy
  );
endinterface

// File: rtl/frame_rr_arbiter.sv
// Round-robin frame arbiter: locks one port from first to last word of a frame
// and forwards its words through a single registered output stage.
module frame_rr_arbiter #(
  parameter int PORT_COUNT = 4,
  parameter int WORD_WIDTH = 64
) (
  input  logic              clock,
  input  logic              clear,
  frame_rr_arbiter_if.slave bus
);
  localparam int PW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                                 state, state_nxt;
  logic [PW-1:0]                          ptr, ptr_nxt, gidx, gidx_nxt, sel_idx;
  logic [PORT_COUNT-1:0]                  grant_q, grant_nxt, xfer_vec;
  logic                                   sel_found, out_free, xfer, xfer_last;
  logic [PORT_COUNT-1:0][WORD_WIDTH-1:0]  port_data;
  logic                                   out_valid_q, out_last_q;
  logic [WORD_WIDTH-1:0]                  out_data_q;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= PORT_COUNT) s -= PORT_COUNT;
    return PW'(s);
  endfunction

  assign port_data = bus.in_data;
  assign out_free  = ~out_valid_q | bus.out_ready;
  // clear gates ready so a requester never sees a word accepted that reset discards
  assign bus.in_ready = (state == LOCKED && !clear) ? (grant_q & {PORT_COUNT{out_free}}) : '0;
  assign xfer_vec  = bus.in_valid & bus.in_ready;
  assign xfer      = |xfer_vec;
  assign xfer_last = |(xfer_vec & bus.in_last);

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = PORT_COUNT-1; k >= 0; k--) begin
      if (bus.in_valid[wrap_add(ptr, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(ptr, k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: if (sel_found) begin
        state_nxt = LOCKED;
        gidx_nxt  = sel_idx;
        grant_nxt = PORT_COUNT'(1) << sel_idx;
      end
      LOCKED: if (xfer_last) begin
        state_nxt = IDLE;
        grant_nxt = '0;
        ptr_nxt   = wrap_add(gidx, 1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      ptr         <= '0;
      gidx        <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gidx    <= gidx_nxt;
      grant_q <= grant_nxt;
      // Load beats drain, so a word can enter while the previous one leaves.
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= port_data[gidx];
        out_last_q  <= bus.in_last[gidx];
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state == LOCKED);
endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Directed bench for frame_rr_arbiter: words are scoreboarded in expected
// egress order and checked as they leave the output register.
module tb_frame_rr_arbiter;
  localparam int P  = 4;
  localparam int W  = 64;
  localparam int SB = W + 1;

  logic clock = 1'b0;
  logic clear;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic [SB-1:0] sb [$];

  frame_rr_arbiter_if #(.PORT_COUNT(P), .WORD_WIDTH(W)) bus ();
  frame_rr_arbiter #(.PORT_COUNT(P), .WORD_WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [SB-1:0] obs, input logic [SB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mkd(input int t, input int p, input int i);
    return {16'hC0DE, 8'(t), 16'(p), 24'(i)};
  endfunction

  // Egress monitor: every accepted output word must match the scoreboard head.
  always @(negedge clock) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) chk("sb_extra_word", SB'(sb.size()), SB'(1));
      else chk("out_word", {bus.out_last, bus.out_data}, sb.pop_front());
    end
  end

  task automatic push_frame(input int p, input int n, input int t);
    for (int i = 0; i < n; i++) sb.push_back({(i == n-1), mkd(t, p, i)});
  endtask

  task automatic wait_xfer(input int p);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.in_ready[p] !== 1'b1 && n < 200);
    chk("xfer_timeout", SB'(bus.in_ready[p]), SB'(1));
    @(posedge clock); #1;
  endtask

  // Drives one frame on port p; gap>0 drops in_valid for gap cycles after word 0.
  task automatic send_frame(input int p, input int n, input int t, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.in_valid[p]        = 1'b1;
      bus.in_data[p*W +: W]  = mkd(t, p, i);
      bus.in_last[p]         = (i == n-1);
      wait_xfer(p);
      if (i == 0 && gap > 0) begin
        bus.in_valid[p] = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clock);
          chk("gap_grant_held", SB'(bus.grant), SB'(1 << p));
          chk("gap_in_ready", SB'(bus.in_ready), SB'(1 << p));
          @(posedge clock); #1;
        end
      end
    end
    bus.in_valid[p] = 1'b0;
    bus.in_last[p]  = 1'b0;
  endtask

  task automatic expect_grant(input string tag, input int exp, output int at);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.grant === '0 && n < 100);
    chk(tag, SB'(bus.grant), SB'(exp));
    at = cyc;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.grant !== '0 && n < 100);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    do begin @(negedge clock); #1; n++; end while ((sb.size() != 0 || bus.out_valid) && n < 200);
    chk(tag, SB'(sb.size()), '0);
    @(posedge clock); #1;
  endtask

  task automatic do_clear();
    clear         = 1'b1;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b1;
    sb.delete();
    @(posedge clock); @(posedge clock); #1;
    clear = 1'b0;
  endtask

  initial begin
    clear       = 1'b1;
    bus.in_data = '0;
    do_clear();

    // 1: reset state, then 3-word frame on port 2
    @(negedge clock);
    chk("t1_rst_grant", SB'(bus.grant), '0);
    chk("t1_rst_busy", SB'(bus.busy), '0);
    chk("t1_rst_out_valid", SB'(bus.out_valid), '0);
    chk("t1_rst_out_last", SB'(bus.out_last), '0);
    chk("t1_rst_out_data", SB'(bus.out_data), '0);
    chk("t1_rst_in_ready", SB'(bus.in_ready), '0);
    @(posedge clock); #1;
    push_frame(2, 3, 10);
    fork
      send_frame(2, 3, 10, 0);
      begin
        @(negedge clock);
        chk("t1_bubble_ready", SB'(bus.in_ready), '0);
        chk("t1_bubble_grant", SB'(bus.grant), '0);
        @(negedge clock);
        chk("t1_grant", SB'(bus.grant), SB'(4));
        chk("t1_busy", SB'(bus.busy), SB'(1));
      end
    join
    wait_drain("t1_drain");
    chk("t1_idle_grant", SB'(bus.grant), '0);
    chk("t1_idle_busy", SB'(bus.busy), '0);

    // 2: all ports requesting, 2-word frames, 3 cycles per frame
    do_clear();
    push_frame(0, 2, 20); push_frame(1, 2, 21); push_frame(2, 2, 22);
    push_frame(3, 2, 23); push_frame(0, 2, 24);
    fork
      begin send_frame(0, 2, 20, 0); send_frame(0, 2, 24, 0); end
      send_frame(1, 2, 21, 0);
      send_frame(2, 2, 22, 0);
      send_frame(3, 2, 23, 0);
      begin
        int t0, t1;
        expect_grant("t2_grant_first", 1, t0);
        for (int k = 1; k < 5; k++) begin
          expect_grant("t2_grant_order", 1 << (k % 4), t1);
          chk("t2_frame_period", SB'(t1 - t0), SB'(3));
          t0 = t1;
        end
      end
    join
    wait_drain("t2_drain");

    // 3: serve port 3, then ports 0 and 2 compete -> wrap to 0
    push_frame(3, 1, 30);
    send_frame(3, 1, 30, 0);
    wait_drain("t3_drain_a");
    push_frame(0, 1, 31); push_frame(2, 1, 32);
    fork
      send_frame(0, 1, 31, 0);
      send_frame(2, 1, 32, 0);
      begin
        int a;
        expect_grant("t3_wrap_port0", 1, a);
        expect_grant("t3_then_port2", 4, a);
      end
    join
    wait_drain("t3_drain_b");

    // 4: downstream stall of 5 cycles mid-frame
    push_frame(1, 4, 40);
    fork
      send_frame(1, 4, 40, 0);
      begin
        int n;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (bus.out_valid !== 1'b1 && n < 50);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          chk("t4_stall_word", {bus.out_last, bus.out_data}, sb[0]);
          chk("t4_stall_in_ready", SB'(bus.in_ready), '0);
          chk("t4_stall_valid", SB'(bus.out_valid), SB'(1));
        end
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // 5: clear on the 2nd word of a frame from port 3
    sb.push_back({1'b0, mkd(50, 3, 0)});
    bus.in_valid[3]       = 1'b1;
    bus.in_data[3*W +: W] = mkd(50, 3, 0);
    bus.in_last[3]        = 1'b0;
    wait_xfer(3);
    bus.in_data[3*W +: W] = mkd(50, 3, 1);
    clear = 1'b1;
    @(negedge clock);
    chk("t5_ready_in_clear", SB'(bus.in_ready), '0);
    @(posedge clock); #1;
    clear           = 1'b0;
    bus.in_valid[3] = 1'b0;
    @(negedge clock);
    chk("t5_out_valid", SB'(bus.out_valid), '0);
    chk("t5_out_last", SB'(bus.out_last), '0);
    chk("t5_out_data", SB'(bus.out_data), '0);
    chk("t5_grant", SB'(bus.grant), '0);
    chk("t5_busy", SB'(bus.busy), '0);
    @(posedge clock); #1;
    chk("t5_sb_empty", SB'(sb.size()), '0);
    push_frame(1, 1, 51); push_frame(3, 1, 52);
    fork
      send_frame(1, 1, 51, 0);
      send_frame(3, 1, 52, 0);
      begin
        int a;
        expect_grant("t5_ptr0_port1", 2, a);
        expect_grant("t5_then_port3", 8, a);
      end
    join
    wait_drain("t5_drain");

    // 6: single-word frames alternating 1,2 twice; then valid drop mid-frame
    for (int r = 0; r < 2; r++) begin
      push_frame(1, 1, 60 + r); push_frame(2, 1, 62 + r);
      fork
        send_frame(1, 1, 60 + r, 0);
        send_frame(2, 1, 62 + r, 0);
        begin
          int a;
          expect_grant("t6_single_p1", 2, a);
          expect_grant("t6_single_p2", 4, a);
        end
      join
      wait_drain("t6_drain_single");
    end
    push_frame(1, 3, 65); push_frame(2, 1, 66);
    fork
      send_frame(1, 3, 65, 3);
      send_frame(2, 1, 66, 0);
      begin
        int a;
        expect_grant("t6_drop_p1", 2, a);
        expect_grant("t6_after_p2", 4, a);
      end
    join
    wait_drain("t6_drain_drop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
